// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: issues sequential word fetches over req/gnt and buffers in-order
// responses with their PCs in a prefetch FIFO toward the core; a redirect flushes everything in flight.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] tag_q        [DEPTH];

  logic credit_ok, grant, resp, keep, pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit covers both buffered words and words still owed by memory, so a push never overflows.
  assign credit_ok = ({1'b0, count_q} + {1'b0, out_q}) < DepthW;
  assign imem_req  = (state_q == StRun) && credit_ok && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (out_q != '0);
  assign keep      = resp && (disc_q == '0);

  assign if_valid = (count_q != '0);
  assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : Nop;
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign pop      = if_valid && if_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    disc_d     = disc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    if (redirect_valid) begin
      // Everything still owed by memory becomes stale; a response landing now is dropped too.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      out_d      = out_q - CW'(resp);
      disc_d     = out_q - CW'(resp);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + AW'(1);
      end
      if (resp) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          tag_rd_d = tag_rd_q + AW'(1);
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      out_d   = out_q + CW'(grant) - CW'(resp);
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= StRun;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[tag_wr_q] <= fetch_pc_q;
    end
    if (keep && !redirect_valid) begin
      fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a small in-order memory model with configurable grant/latency
// and a consumer recorder; each task drives one scenario and checks results inline.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gnt_rand = 0;
  int lat_max  = 1;
  int budget   = -1;  // responses memory may still return; -1 = unlimited

  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  int          pend_lat[$];
  logic [31:0] gnt_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5EED_0001;
  endfunction

  // Memory bookkeeping and consumer recorder, sampled at the active edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      pend_addr.delete();
      pend_cyc.delete();
      pend_lat.delete();
    end else begin
      if (imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_cyc.pop_front());
        void'(pend_lat.pop_front());
        if (budget > 0) budget <= budget - 1;
      end
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_cyc.push_back(cyc);
        pend_lat.push_back(int'($urandom_range(lat_max, 1)));
        gnt_addr.push_back(imem_addr);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        got_pc.push_back(if_pc);
        got_instr.push_back(if_instr);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    imem_gnt = (gnt_rand != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
    if (reset_n && budget != 0 && pend_addr.size() > 0 && cyc >= pend_cyc[0] + pend_lat[0]) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    gnt_rand = 0;
    lat_max = 1;
    budget = -1;
    repeat (2) tick();
    gnt_addr.delete();
    got_pc.delete();
    got_instr.delete();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_ready = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_tests++; if (if_instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", if_instr, NOP); end
    n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    tick();
    reset_n = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", imem_req); end
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL run_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    repeat (6) tick();
    n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", if_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL async_rst: got valid=%b req=%b addr=%h want 0 0 0", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    if_ready = 1'b1;
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL seq_first_req: got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    tick();
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_early_valid: got %b want 0", if_valid); end
    tick();
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== memf(32'h0)) begin
      n_fail++; $display("FAIL seq_first_out: got v=%b pc=%h instr=%h want 1 0 %h", if_valid, if_pc, if_instr, memf(32'h0));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_stream cycle %0d: got %b want 1", i, if_valid); end
    end
    n_tests++; if (got_pc.size() !== 20) begin n_fail++; $display("FAIL seq_count: got %0d want 20", got_pc.size()); end
    for (int i = 0; i < 20 && i < got_pc.size(); i++) begin
      n_tests++; if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== memf(32'(4 * i))) begin
        n_fail++; $display("FAIL seq_item %0d: got pc=%h instr=%h want pc=%h", i, got_pc[i], got_instr[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (10) tick();
    n_tests++; if (gnt_addr.size() !== 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", gnt_addr.size()); end
    for (int i = 0; i < 4 && i < gnt_addr.size(); i++) begin
      n_tests++; if (gnt_addr[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_addr %0d: got %h want %h", i, gnt_addr[i], 32'(4 * i)); end
    end
    n_tests++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_fail++; $display("FAIL bp_full: got req=%b v=%b pc=%h want 0 1 0", imem_req, if_valid, if_pc);
    end
    if_ready = 1'b1;
    repeat (12) tick();
    n_tests++; if (got_pc.size() < 4) begin n_fail++; $display("FAIL bp_drain: got %0d want >=4", got_pc.size()); end
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      n_tests++; if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== memf(32'(4 * i))) begin
        n_fail++; $display("FAIL bp_order %0d: got pc=%h instr=%h want pc=%h", i, got_pc[i], got_instr[i], 32'(4 * i));
      end
    end
    n_tests++; if (gnt_addr.size() < 5 || gnt_addr[4] !== 32'h10) begin
      n_fail++; $display("FAIL bp_resume: got n=%0d want grant[4]=00000010", gnt_addr.size());
    end
  endtask

  task automatic test_random();
    logic        req_prev;
    logic [31:0] addr_prev;
    int          guard;
    do_reset();
    gnt_rand = 1;
    lat_max = 3;
    req_prev = 1'b0;
    addr_prev = 32'h0;
    guard = 0;
    while (got_pc.size() < 200 && guard < 5000) begin
      req_prev = imem_req;
      addr_prev = imem_addr;
      if_ready = 1'($urandom_range(1, 0));
      tick();
      guard++;
      if (req_prev && !imem_gnt) begin
        n_tests++; if (imem_addr !== addr_prev) begin
          n_fail++; $display("FAIL rnd_addr_stable: got %h want %h", imem_addr, addr_prev);
        end
      end
    end
    n_tests++; if (got_pc.size() < 200) begin n_fail++; $display("FAIL rnd_timeout: got %0d want 200", got_pc.size()); end
    for (int i = 0; i < 200 && i < got_pc.size(); i++) begin
      n_tests++; if (got_pc[i] !== 32'(4 * i) || got_instr[i] !== memf(32'(4 * i))) begin
        n_fail++; $display("FAIL rnd_item %0d: got pc=%h instr=%h want pc=%h", i, got_pc[i], got_instr[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    if_ready = 1'b1;
    budget = 0;
    for (int i = 0; i < 10 && gnt_addr.size() < 2; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    budget = -1;
    #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_next: got req=%b addr=%h v=%b want 1 00000100 0", imem_req, imem_addr, if_valid);
    end
    for (int i = 0; i < 30 && got_pc.size() < 2; i++) tick();
    n_tests++; if (gnt_addr.size() < 3 || gnt_addr[2] !== 32'h100) begin
      n_fail++; $display("FAIL redir_grant: got n=%0d want grant[2]=00000100", gnt_addr.size());
    end
    n_tests++; if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_instr[0] !== memf(32'h100) || got_pc[1] !== 32'h104) begin
      n_fail++; $display("FAIL redir_out: got n=%0d want pcs 00000100,00000104", got_pc.size());
    end
  endtask

  task automatic test_redirect_with_resp();
    logic [31:0] exp;
    do_reset();
    budget = 0;
    for (int i = 0; i < 12 && gnt_addr.size() < 4; i++) tick();
    budget = 2;
    repeat (4) tick();
    n_tests++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rr_setup: got v=%b req=%b want 1 0", if_valid, imem_req);
    end
    budget = 1;
    @(negedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    if_ready = 1'b1;
    n_tests++; if (imem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rr_rvalid: got %b want 1", imem_rvalid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP) begin
      n_fail++; $display("FAIL rr_flush: got v=%b pc=%h instr=%h want 0 0 %h", if_valid, if_pc, if_instr, NOP);
    end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL rr_req: got req=%b addr=%h want 1 00000200", imem_req, imem_addr);
    end
    budget = -1;
    for (int i = 0; i < 40 && got_pc.size() < 3; i++) tick();
    n_tests++; if (got_pc.size() < 3) begin n_fail++; $display("FAIL rr_timeout: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      exp = 32'h200 + 32'(4 * i);
      n_tests++; if (got_pc[i] !== exp || got_instr[i] !== memf(exp)) begin
        n_fail++; $display("FAIL rr_item %0d: got pc=%h instr=%h want pc=%h instr=%h", i, got_pc[i], got_instr[i], exp, memf(exp));
      end
    end
  endtask

  task automatic test_wrap_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'hFFFF_FFF8;
    exp[1] = 32'hFFFF_FFFC;
    exp[2] = 32'h0000_0000;
    exp[3] = 32'h0000_0004;
    do_reset();
    if_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_tests++; if (imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_last_wins: got %h want FFFFFFF8", imem_addr); end
    got_pc.delete();
    got_instr.delete();
    for (int i = 0; i < 30 && got_pc.size() < 4; i++) tick();
    n_tests++; if (got_pc.size() < 4) begin n_fail++; $display("FAIL wrap_timeout: got %0d want 4", got_pc.size()); end
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      n_tests++; if (got_pc[i] !== exp[i] || got_instr[i] !== memf(exp[i])) begin
        n_fail++; $display("FAIL wrap_item %0d: got pc=%h instr=%h want pc=%h", i, got_pc[i], got_instr[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_random();
    test_redirect();
    test_redirect_with_resp();
    test_wrap_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
